// File: rtl/uart_pkg.sv
// Shared types for the parametrised UART: parity modes, FSM states and
// the parity helper used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10,
    PAR_RSVD = 2'b11
  } par_mode_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  // Parity bit for up to 9 data bits; callers zero-extend narrower words,
  // which leaves the reduction XOR unchanged.
  function automatic logic calc_parity(input logic [8:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

  function automatic logic par_enabled(input par_mode_e mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_cfg_if.sv
// Host-side bus of uart_cfg: transmit request/status and receive word/flags.
interface uart_cfg_if
  import uart_pkg::*;
#(
  parameter int DATA_W = 8
) ();

  logic              trmt;
  logic [DATA_W-1:0] tx_data;
  par_mode_e         par_mode;
  logic              tx_done;
  logic              tx_busy;
  logic              clr_rdy;
  logic [DATA_W-1:0] rx_data;
  logic              rdy;
  logic              frame_err;
  logic              par_err;
  logic              overrun;

  modport master (
    output trmt, tx_data, par_mode, clr_rdy,
    input  tx_done, tx_busy, rx_data, rdy, frame_err, par_err, overrun
  );

  modport slave (
    input  trmt, tx_data, par_mode, clr_rdy,
    output tx_done, tx_busy, rx_data, rdy, frame_err, par_err, overrun
  );

endinterface

// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop RX synchroniser, mid-bit sampling FSM with start
// glitch rejection, and sticky frame/parity/overrun flags.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 2604,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RX,
  input  par_mode_e         par_mode,
  input  logic              clr_rdy,
  output logic [DATA_W-1:0] rx_data,
  output logic              rdy,
  output logic              frame_err,
  output logic              par_err,
  output logic              overrun
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic              prev_q, prev_d;
  logic              par_en_q, par_en_d;
  logic              par_odd_q, par_odd_d;
  logic              perr_pend_q, perr_pend_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rdy_q, rdy_d;
  logic              frame_err_q, frame_err_d;
  logic              par_err_q, par_err_d;
  logic              overrun_q, overrun_d;
  logic              tick;

  // Next-state: sampling FSM; clr_rdy is applied first so that a frame
  // completing in the same cycle re-sets rdy and its own flags.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shreg_d     = shreg_q;
    par_en_d    = par_en_q;
    par_odd_d   = par_odd_q;
    perr_pend_d = perr_pend_q;
    rx_data_d   = rx_data_q;
    rdy_d       = rdy_q;
    frame_err_d = frame_err_q;
    par_err_d   = par_err_q;
    overrun_d   = overrun_q;
    sync1_d     = RX;
    sync2_d     = sync1_q;
    prev_d      = sync2_q;
    tick        = (cnt_q == '0);

    if (clr_rdy) begin
      rdy_d       = 1'b0;
      frame_err_d = 1'b0;
      par_err_d   = 1'b0;
      overrun_d   = 1'b0;
    end

    if (state_q != RX_IDLE && !tick) begin
      cnt_d = cnt_q - 1'b1;
    end

    unique case (state_q)
      RX_IDLE: begin
        if (prev_q && !sync2_q) begin
          state_d     = RX_START;
          cnt_d       = HALF_BIT;
          par_en_d    = par_enabled(par_mode);
          par_odd_d   = (par_mode == PAR_ODD);
          perr_pend_d = 1'b0;
        end
      end
      RX_START: begin
        if (tick) begin
          if (sync2_q) begin
            state_d = RX_IDLE;
          end else begin
            state_d = RX_DATA;
            cnt_d   = FULL_M1;
            idx_d   = '0;
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          shreg_d = {sync2_q, shreg_q[DATA_W-1:1]};
          cnt_d   = FULL_M1;
          if (idx_q == LAST_IDX) begin
            state_d = par_en_q ? RX_PARITY : RX_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      RX_PARITY: begin
        if (tick) begin
          perr_pend_d = (sync2_q != calc_parity(9'(shreg_q), par_odd_q));
          cnt_d       = FULL_M1;
          state_d     = RX_STOP;
        end
      end
      RX_STOP: begin
        if (tick) begin
          state_d     = RX_IDLE;
          rx_data_d   = shreg_q;
          rdy_d       = 1'b1;
          frame_err_d = frame_err_d | ~sync2_q;
          par_err_d   = par_err_d | perr_pend_q;
          if (rdy_q && !clr_rdy) begin
            overrun_d = 1'b1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // State and output registers; synchroniser flops idle high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RX_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shreg_q     <= '0;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      prev_q      <= 1'b1;
      par_en_q    <= 1'b0;
      par_odd_q   <= 1'b0;
      perr_pend_q <= 1'b0;
      rx_data_q   <= '0;
      rdy_q       <= 1'b0;
      frame_err_q <= 1'b0;
      par_err_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      par_en_q    <= par_en_d;
      par_odd_q   <= par_odd_d;
      perr_pend_q <= perr_pend_d;
      rx_data_q   <= rx_data_d;
      rdy_q       <= rdy_d;
      frame_err_q <= frame_err_d;
      par_err_q   <= par_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rdy       = rdy_q;
  assign frame_err = frame_err_q;
  assign par_err   = par_err_q;
  assign overrun   = overrun_q;

endmodule

// File: rtl/uart_cfg.sv
// Parametrised full-duplex UART: inline transmitter FSM plus uart_rx_core.
module uart_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 2604,
  parameter int DATA_W       = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  uart_cfg_if.slave  host,
  output logic       TX,
  input  logic       RX
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] FULL_M1   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_W - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

  tx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              stop_idx_q, stop_idx_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              par_en_q, par_en_d;
  logic              par_bit_q, par_bit_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              tick;

  // Next-state: transmit sequencer; TX is derived from the next state so
  // the serial line comes straight from a flop.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    stop_idx_d = stop_idx_q;
    shreg_d    = shreg_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    busy_d     = busy_q;
    done_d     = done_q;
    tick       = (cnt_q == FULL_M1);

    if (state_q != TX_IDLE) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    unique case (state_q)
      TX_IDLE: begin
        if (host.trmt) begin
          state_d   = TX_START;
          cnt_d     = '0;
          shreg_d   = host.tx_data;
          par_en_d  = par_enabled(host.par_mode);
          par_bit_d = calc_parity(9'(host.tx_data), host.par_mode == PAR_ODD);
          busy_d    = 1'b1;
          done_d    = 1'b0;
        end
      end
      TX_START: begin
        if (tick) begin
          state_d = TX_DATA;
          idx_d   = '0;
        end
      end
      TX_DATA: begin
        if (tick) begin
          shreg_d = shreg_q >> 1;
          if (idx_q == LAST_IDX) begin
            state_d    = par_en_q ? TX_PARITY : TX_STOP;
            stop_idx_d = 1'b0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      TX_PARITY: begin
        if (tick) begin
          state_d    = TX_STOP;
          stop_idx_d = 1'b0;
        end
      end
      TX_STOP: begin
        if (tick) begin
          if (stop_idx_q == LAST_STOP) begin
            state_d = TX_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            stop_idx_d = stop_idx_q + 1'b1;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase

    unique case (state_d)
      TX_START:  tx_d = 1'b0;
      TX_DATA:   tx_d = shreg_d[0];
      TX_PARITY: tx_d = par_bit_d;
      default:   tx_d = 1'b1;
    endcase
  end

  // Transmitter registers; line idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= TX_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      stop_idx_q <= 1'b0;
      shreg_q    <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      stop_idx_q <= stop_idx_d;
      shreg_q    <= shreg_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign TX           = tx_q;
  assign host.tx_busy = busy_q;
  assign host.tx_done = done_q;

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .DATA_W      (DATA_W)
  ) u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .RX       (RX),
    .par_mode (host.par_mode),
    .clr_rdy  (host.clr_rdy),
    .rx_data  (host.rx_data),
    .rdy      (host.rdy),
    .frame_err(host.frame_err),
    .par_err  (host.par_err),
    .overrun  (host.overrun)
  );

endmodule
